// File: rtl/design_selector_if.sv
// Bus bundle for design_selector: host-side select/data and the per-project fan-out.
// slave = selector side, master = host plus project array.
interface design_selector_if #(
  parameter int NUM_DESIGNS = 8,
  parameter int SEL_BITS    = $clog2(NUM_DESIGNS + 1),
  parameter int INPUT_BITS  = 16,
  parameter int OUTPUT_BITS = 16
);
  logic [SEL_BITS-1:0]                sel;
  logic [INPUT_BITS-1:0]              in;
  logic [OUTPUT_BITS-1:0]             out;
  logic                               busy;
  logic [SEL_BITS-1:0]                active;
  logic [NUM_DESIGNS-1:0]             proj_clk_en;
  logic [NUM_DESIGNS-1:0]             proj_rst_n;
  logic [NUM_DESIGNS*INPUT_BITS-1:0]  proj_in;
  logic [NUM_DESIGNS*OUTPUT_BITS-1:0] proj_out;

  modport master (
    output sel, in, proj_out,
    input  out, busy, active, proj_clk_en, proj_rst_n, proj_in
  );

  modport slave (
    input  sel, in, proj_out,
    output out, busy, active, proj_clk_en, proj_rst_n, proj_in
  );
endinterface

// File: rtl/design_selector.sv
// Routes shared in/out buses to one of NUM_DESIGNS projects and sequences project switches
// (drain under reset, all-off, wake under reset). Define DESIGN_SEL_OUTREG_EN to register out.
module design_selector #(
  parameter int NUM_DESIGNS = 8,
  parameter int SEL_BITS    = $clog2(NUM_DESIGNS + 1),
  parameter int INPUT_BITS  = 16,
  parameter int OUTPUT_BITS = 16,
  parameter int RST_CYCLES  = 4
) (
  input logic              clk,
  input logic              rst_n,
  design_selector_if.slave bus
);
  localparam int CNT_BITS = $clog2(RST_CYCLES + 1);
  localparam logic [SEL_BITS-1:0] NONE     = SEL_BITS'(NUM_DESIGNS);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(RST_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, OFF, WAKE} state_e;

  state_e                          state_q, state_d;
  logic [CNT_BITS-1:0]             cnt_q, cnt_d;
  logic [SEL_BITS-1:0]             sel_d, sel_q, sel_qq;
  logic [SEL_BITS-1:0]             target_q, target_d;
  logic [SEL_BITS-1:0]             active_q, active_d;
  logic                            busy_q, busy_d;
  logic [NUM_DESIGNS-1:0]          en_q, en_d;
  logic [NUM_DESIGNS-1:0]          rstn_q, rstn_d;
  logic [OUTPUT_BITS-1:0]          mux_out;
  logic [NUM_DESIGNS*INPUT_BITS-1:0] proj_in_c;
  logic                            req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      sel_q    <= NONE;
      sel_qq   <= NONE;
      target_q <= NONE;
      active_q <= NONE;
      busy_q   <= 1'b1;
      en_q     <= '0;
      rstn_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sel_qq   <= sel_q;
      target_q <= target_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      rstn_q   <= rstn_d;
    end
  end

  always_comb begin
    sel_d    = (bus.sel >= NONE) ? NONE : bus.sel;
    req      = (sel_q == sel_qq) && (sel_qq != active_q);
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    active_d = active_q;
    unique case (state_q)
      RUN: begin
        if (req) begin
          target_d = sel_qq;
          if (active_q == NONE) begin
            state_d = OFF;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = OFF;
        else             cnt_d   = cnt_q - CNT_BITS'(1);
      end
      OFF: begin
        active_d = target_q;
        if (target_q == NONE) begin
          state_d = RUN;
        end else begin
          state_d = WAKE;
          cnt_d   = CNT_LOAD;
        end
      end
      WAKE: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_BITS'(1);
      end
      default: state_d = RUN;
    endcase
  end

  // Registered outputs are computed from next-state values so they line up with state_q.
  always_comb begin
    busy_d    = (state_d != RUN);
    en_d      = '0;
    rstn_d    = '0;
    mux_out   = '0;
    proj_in_c = '0;
    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      if (active_d == SEL_BITS'(i)) begin
        unique case (state_d)
          RUN: begin
            en_d[i]   = 1'b1;
            rstn_d[i] = 1'b1;
          end
          DRAIN, WAKE: en_d[i] = 1'b1;
          default: ;
        endcase
      end
      if (state_q == RUN && active_q == SEL_BITS'(i)) begin
        proj_in_c[i*INPUT_BITS +: INPUT_BITS] = bus.in;
        mux_out = bus.proj_out[i*OUTPUT_BITS +: OUTPUT_BITS];
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.active      = active_q;
  assign bus.proj_clk_en = en_q;
  assign bus.proj_rst_n  = rstn_q;
  assign bus.proj_in     = proj_in_c;

`ifdef DESIGN_SEL_OUTREG_EN
  logic [OUTPUT_BITS-1:0] out_q, out_d;

  always_comb out_d = mux_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign bus.out = out_q;
`else
  assign bus.out = mux_out;
`endif
endmodule

// File: tb/tb_design_selector.sv
// Scoreboard bench for design_selector: a timeline model of each switch pushes per-cycle
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_design_selector;
  localparam int ND = 8;
  localparam int SB = $clog2(ND + 1);
  localparam int IB = 16;
  localparam int OB = 16;
  localparam int R  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  design_selector_if #(.NUM_DESIGNS(ND), .SEL_BITS(SB), .INPUT_BITS(IB), .OUTPUT_BITS(OB)) bus ();

  design_selector #(
    .NUM_DESIGNS(ND), .SEL_BITS(SB), .INPUT_BITS(IB), .OUTPUT_BITS(OB), .RST_CYCLES(R)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int                  cyc;
    logic                busy;
    int                  act;
    logic [ND-1:0]       en;
    logic [ND-1:0]       rstn;
    logic [OB-1:0]       out;
    logic [ND*IB-1:0]    pin;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: a switch is a timeline starting at cycle 'start':
  // drain_len cycles draining old_act, one all-off cycle, then R wake cycles (if tgt valid).
  int cur_sel;
  int s1, s2;
  int act, old_act, tgt, start, drain_len, len, cyc;
  bit inseq;
  logic [OB-1:0] mux_prev;
  int rst_hold;
  bit armed;

  function automatic int norm(input int v);
    return (v >= ND) ? ND : v;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e.cyc  = cyc;
    e.busy = 1'b1;
    e.act  = ND;
    e.en   = '0;
    e.rstn = '0;
    e.out  = '0;
    e.pin  = '0;
    return e;
  endfunction

  task automatic model_reset();
    act      = ND;
    inseq    = 0;
    s1       = ND;
    s2       = ND;
    mux_prev = '0;
  endtask

  task automatic model_edge();
    cyc++;
    if (inseq && (cyc - 1 - start) >= len) begin
      inseq = 0;
      act   = tgt;
    end
    if (!inseq && s1 == s2 && s1 != act) begin
      inseq     = 1;
      start     = cyc;
      old_act   = act;
      tgt       = s1;
      drain_len = (act == ND) ? 0 : R;
      len       = drain_len + 1 + ((tgt == ND) ? 0 : R);
    end
    s2 = s1;
    s1 = norm(cur_sel);
  endtask

  function automatic exp_t expect_now(input logic [IB-1:0] in_v, input logic [ND*OB-1:0] po);
    exp_t e;
    int   a;
    int   age;
    e.cyc  = cyc;
    e.en   = '0;
    e.rstn = '0;
    e.pin  = '0;
    e.out  = '0;
    e.busy = 1'b0;
    a      = act;
    if (inseq) begin
      age = cyc - start;
      if (age >= len) begin
        a = tgt;
      end else begin
        e.busy = 1'b1;
        if (age < drain_len) begin
          a = old_act;
          e.en[old_act] = 1'b1;
        end else if (age == drain_len) begin
          a = old_act;
        end else begin
          a = tgt;
          e.en[tgt] = 1'b1;
        end
      end
    end
    e.act = a;
    if (!e.busy && a != ND) begin
      e.en[a]   = 1'b1;
      e.rstn[a] = 1'b1;
      e.pin[a*IB +: IB] = in_v;
      e.out = po[a*OB +: OB];
    end
    return e;
  endfunction

  task automatic cycle(input int sel_v);
    exp_t          e;
    logic [OB-1:0] tmp;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    bus.sel = SB'(sel_v);
    cur_sel = sel_v;
    bus.in  = IB'($urandom);
    for (int i = 0; i < ND; i++) bus.proj_out[i*OB +: OB] = OB'($urandom);
    if (!rst_n) begin
      e = reset_rec();
      mux_prev = '0;
    end else begin
      e = expect_now(bus.in, bus.proj_out);
`ifdef DESIGN_SEL_OUTREG_EN
      tmp      = e.out;
      e.out    = mux_prev;
      mux_prev = tmp;
`else
      tmp = '0;
`endif
    end
    q.push_back(e);
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) begin
        #1 rst_n = 1'b1;
      end
    end else if (armed && inseq && drain_len == R && (cyc - start) == 1) begin
      // Mid-DRAIN async reset: the current cycle's expectation becomes the reset state.
      #1 rst_n = 1'b0;
      q[q.size()-1] = reset_rec();
      model_reset();
      rst_hold = 3;
      armed    = 0;
    end
  endtask

  task automatic hold(input int sel_v, input int n);
    for (int i = 0; i < n; i++) cycle(sel_v);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.busy !== e.busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b want=%b", e.cyc, bus.busy, e.busy);
      end
      checks++;
      if ($isunknown(bus.active) || int'(bus.active) != e.act) begin
        failures++;
        $display("FAIL active cyc=%0d got=%0d want=%0d", e.cyc, bus.active, e.act);
      end
      checks++;
      if (bus.proj_clk_en !== e.en) begin
        failures++;
        $display("FAIL proj_clk_en cyc=%0d got=%b want=%b", e.cyc, bus.proj_clk_en, e.en);
      end
      checks++;
      if (bus.proj_rst_n !== e.rstn) begin
        failures++;
        $display("FAIL proj_rst_n cyc=%0d got=%b want=%b", e.cyc, bus.proj_rst_n, e.rstn);
      end
      checks++;
      if (bus.out !== e.out) begin
        failures++;
        $display("FAIL out cyc=%0d got=%h want=%h", e.cyc, bus.out, e.out);
      end
      checks++;
      if (bus.proj_in !== e.pin) begin
        failures++;
        $display("FAIL proj_in cyc=%0d got=%h want=%h", e.cyc, bus.proj_in, e.pin);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.sel      = SB'(2);
    bus.in       = '0;
    bus.proj_out = '0;
    cur_sel      = 2;
    cyc          = 0;
    armed        = 0;
    rst_hold     = 3;
    model_reset();

    hold(2, 20);          // first selection out of reset
    hold(5, 20);          // full switch 2 -> 5
    hold(6, 1);           // one-cycle glitch
    hold(5, 10);
    hold(2, 20);
    hold(5, 10);          // 5 -> 1 lands during WAKE of 5
    hold(1, 25);
    hold(15, 20);         // out of range maps to none
    hold(3, 20);

    armed = 1;
    for (int ep = 0; ep < 250; ep++) begin
      hold($urandom_range(0, 15), $urandom_range(1, 18));
    end
    hold(4, 20);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    checks++;
    if (armed) begin
      failures++;
      $display("FAIL async_reset_exercised got=0 want=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/design_selector.md
# design_selector

Parametrised successor to the fixed-count project input/output muxes: it routes one shared input bus and one shared output bus to one of `NUM_DESIGNS` user projects, and sequences every project change. It sits between the Caravel interface block and the project instances. A project change resets the outgoing project and quiesces its clock enable. It then wakes the incoming project under reset, so no project ever sees a partial selection or glitching inputs.

## Interface
- `NUM_DESIGNS`, 8: number of project slots (2–64).
- `SEL_BITS`, `$clog2(NUM_DESIGNS+1)`: selector width; one code above the last slot is always available as "none".
- `INPUT_BITS`, 16: shared input bus width.
- `OUTPUT_BITS`, 16: shared output bus width.
- `RST_CYCLES`, 4: cycles a project is held in reset with its clock enabled (1–255).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sel`  in  `SEL_BITS`  requested project; asynchronous to the switch sequence.
- `in`  in  `INPUT_BITS`  shared input bus.
- `out`  out  `OUTPUT_BITS`  shared output bus.
- `busy`  out  1  high whenever the block is not in RUN.
- `active`  out  `SEL_BITS`  currently connected slot; `NUM_DESIGNS` means none.
- `proj_clk_en`  out  `NUM_DESIGNS`  per-project clock enable; the external gating cell consumes it.
- `proj_rst_n`  out  `NUM_DESIGNS`  per-project active-low reset.
- `proj_in`  out  `NUM_DESIGNS*INPUT_BITS`  slot i occupies `[i*INPUT_BITS +: INPUT_BITS]`.
- `proj_out`  in  `NUM_DESIGNS*OUTPUT_BITS`  slot i occupies `[i*OUTPUT_BITS +: OUTPUT_BITS]`.

## Operation
- **Selector qualification:** `sel` passes through a two-flop register chain (`sel_q`, `sel_qq`). A request is valid when `sel_q == sel_qq != active`. Any `sel` value ≥ `NUM_DESIGNS` maps to none.
- **States:** RUN, DRAIN, OFF, WAKE. A down-counter of width `$clog2(RST_CYCLES+1)` times DRAIN and WAKE.
- **RUN:**
  - Slot `active` has `proj_clk_en=1`, `proj_rst_n=1`, and `proj_in` equal to `in`.
  - All other slots have clock enable 0, reset 0, and input 0.
  - `out` equals `proj_out[active]`, or 0 when `active` is none.
  - A valid request latches `target` and moves to DRAIN. If `active` is none, it skips directly to OFF.
- **DRAIN:**
  - The old slot sees `proj_rst_n=0` while `proj_clk_en` stays 1, so synchronous resets complete.
  - Its `proj_in` is 0 and `out` is 0.
  - The state lasts `RST_CYCLES` cycles, then moves to OFF.
- **OFF:**
  - This state lasts exactly 1 cycle. All enables are 0 and all resets are 0.
  - `active` is loaded from `target`.
  - The next state is WAKE, or RUN if `target` is none.
- **WAKE:**
  - The new slot sees `proj_clk_en=1` and `proj_rst_n=0`.
  - Its `proj_in` is 0 and `out` is 0.
  - The state lasts `RST_CYCLES` cycles, then moves to RUN.
- **Requests during DRAIN/OFF/WAKE:** these are not acted on in the current sequence; the sequence always completes to the latched `target`. In RUN, the still-differing `sel` is qualified again and starts a new switch.
- **Re-selecting the current slot:** if `sel` returns to the old value during DRAIN, the sequence still completes. The net effect is a reset pulse of `2*RST_CYCLES+1` cycles on that slot.
- **Reset assertion:** asynchronous reset at any point, including mid-sequence, forces the reset state immediately.

## Timing
- **Reset values:**
  - `out=0`, `busy=1`, `active=NUM_DESIGNS` (none).
  - All `proj_clk_en` are 0 and all `proj_rst_n` are 0.
  - `sel_q` and `sel_qq` reset to none.
  - State resets to RUN with `active` none; `busy` drops to 0 on the first clock after reset release.
- **Switch latency:** `sel` change to the first cycle of DRAIN takes 3 clocks (2 sync stages plus state register).
- **Full switch duration:** `2*RST_CYCLES+1` busy cycles. With default parameters the new slot is in RUN 12 clocks after the `sel` edge.
- **Combinational paths:**
  - `proj_in` gating follows the registered state; `in` to `proj_in` is combinational.
  - `proj_out` to `out` is combinational unless `DESIGN_SEL_OUTREG_EN` is defined.
- **Registered outputs:** `busy`, `active`, `proj_clk_en`, and `proj_rst_n` are registered outputs and are glitch-free.

## Configuration
- `DESIGN_SEL_OUTREG_EN` defined:
  - `out` is registered, giving 1 extra cycle of `proj_out` to `out` latency. The register resets to 0.
  - The register loads 0 on any cycle where the state is not RUN.
- Undefined: `out` is the combinational masked mux.
- No other behaviour changes.

## Test plan
- **Reset to first selection:** reset with `sel=2`, release → `active=8` (none) for one cycle, then `busy=1` through OFF and WAKE. `proj_rst_n[2]` stays 0 for 4 cycles with `proj_clk_en[2]=1`. It then rises, and `out` follows `proj_out[2]`.
- **Full switch:** switch 2→5 in RUN → `busy` rises 3 clocks after `sel`.
  - `proj_rst_n[2]` is 0 for 4 cycles with its enable held, then `proj_clk_en[2]` drops.
  - `proj_clk_en[5]` rises one cycle later.
  - Slot 5 reaches RUN at +12 clocks.
  - `out=0` throughout the busy window.
- **Selector glitch:** 1-cycle `sel` glitch to 6 while running slot 5 → no switch, `busy` stays 0.
- **Mid-sequence change:** `sel` 5→1 during WAKE of 5 → slot 5 completes WAKE, enters RUN for 1 cycle, then switches to 1.
- **Out-of-range selection:** `sel=15` with `NUM_DESIGNS=8` → DRAIN, OFF, then RUN with `active=8`, all enables 0, `out=0`.
- **Asynchronous reset mid-DRAIN:** assert `rst_n` low in the middle of DRAIN → all outputs reach their reset values without waiting for a clock edge. With `DESIGN_SEL_OUTREG_EN`, check the 1-cycle extra `out` delay in RUN.
